// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART command decoder for cat shooting flags and AES key store
module uart_cmd_decoder #(
    parameter int unsigned     TIMEOUT_CYCLES = 10_334_000,
    parameter int unsigned     TO_BITS        = 24,
    parameter logic [7:0]      CMD_FLAGS      = 8'd65,
    parameter logic [7:0]      CMD_KEY        = 8'd66
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [7:0]         rx_byte,
    output logic               rd_uart,
    output logic [7:0]         cat_status,
    output logic [127:0]       key_out,
    output logic               key_valid,
    output logic               cmd_err,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, F_ARG, F_END, K_DATA, K_END} state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nx;
    logic [7:0]           arg, arg_nx;
    logic [3:0]           cnt, cnt_nx;
    logic [127:0]         stage, stage_nx;
    logic [TO_BITS-1:0]   to_cnt, to_nx;
    logic [7:0]           cat_nx;
    logic [127:0]         key_nx;
    logic                 kv_nx, err_nx;
    logic                 pop;

    // The FIFO head is fall-through, so a byte is consumed whenever one is present.
    assign pop     = ~rx_empty & ~reset;
    assign rd_uart = pop;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        arg_nx   = arg;
        cnt_nx   = cnt;
        stage_nx = stage;
        cat_nx   = cat_status;
        key_nx   = key_out;
        kv_nx    = 1'b0;
        err_nx   = 1'b0;
        to_nx    = to_cnt;

        if (state == IDLE || pop)
            to_nx = '0;
        else if (to_cnt != TO_LAST)
            to_nx = to_cnt + 1'b1;

        if (pop) begin
            case (state)
                IDLE: begin
                    if (rx_byte == CMD_FLAGS) begin
                        state_nx = F_ARG;
                    end else if (rx_byte == CMD_KEY) begin
                        state_nx = K_DATA;
                        cnt_nx   = '0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                F_ARG: begin
                    arg_nx   = rx_byte;
                    state_nx = F_END;
                end
                F_END: begin
                    state_nx = IDLE;
                    if (rx_byte == CMD_FLAGS && arg == 8'd96)
                        cat_nx = 8'hFF;
                    else if (rx_byte == CMD_FLAGS && arg >= 8'd65 && arg <= 8'd72)
                        cat_nx = cat_status & ~(8'd1 << (arg - 8'd65));
                    else
                        err_nx = 1'b1;
                end
                K_DATA: begin
                    // Command bytes here are plain key data; only the terminator is checked.
                    stage_nx = {stage[119:0], rx_byte};
                    cnt_nx   = cnt + 4'd1;
                    if (cnt == 4'd15)
                        state_nx = K_END;
                end
                K_END: begin
                    state_nx = IDLE;
                    if (rx_byte == CMD_KEY) begin
                        key_nx = stage;
                        kv_nx  = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            arg        <= '0;
            cnt        <= '0;
            stage      <= '0;
            to_cnt     <= '0;
            cat_status <= 8'hFF;
            key_out    <= '0;
            key_valid  <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            arg        <= arg_nx;
            cnt        <= cnt_nx;
            stage      <= stage_nx;
            to_cnt     <= to_nx;
            cat_status <= cat_nx;
            key_out    <= key_nx;
            key_valid  <= kv_nx;
            cmd_err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    logic         clk;
    logic         reset;
    logic         rx_empty;
    logic [7:0]   rx_byte;
    logic         rd_uart;
    logic [7:0]   cat_status;
    logic [127:0] key_out;
    logic         key_valid;
    logic         cmd_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int kv_cnt   = 0;
    int rd_viol  = 0;
    int both_viol = 0;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (16),
        .TO_BITS        (5),
        .CMD_FLAGS      (8'd65),
        .CMD_KEY        (8'd66)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .rx_byte    (rx_byte),
        .rd_uart    (rd_uart),
        .cat_status (cat_status),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err)   err_cnt++;
        if (key_valid) kv_cnt++;
        if (rd_uart && rx_empty) rd_viol++;
        if (key_valid && cmd_err) both_viol++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_empty = 1'b0;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_empty = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] first, input logic [7:0] term);
        send_byte(8'd66);
        for (int i = 0; i < 16; i++) send_byte(first + 8'(i));
        send_byte(term);
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_empty = 1'b0; rx_byte = 8'd65;
        idle(2);
        checks++;
        if (rd_uart !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rd=%b busy=%b kv=%b err=%b expected 0 0 0 0", rd_uart, busy, key_valid, cmd_err);
        end
        checks++;
        if (cat_status !== 8'hFF || key_out !== 128'h0) begin
            failures++;
            $display("FAIL reset_data: cat=%h key=%h expected ff 0", cat_status, key_out);
        end
        rx_empty = 1'b1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        int pops;
        int e0;
        seq[0] = 8'd65; seq[1] = 8'd67; seq[2] = 8'd65;
        pops = 0;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            rx_empty = 1'b0;
            rx_byte  = seq[i];
            #1;
            if (rd_uart === 1'b1) pops++;
            @(posedge clk);
            #1;
        end
        rx_empty = 1'b1;
        checks++;
        if (cat_status !== 8'hFB) begin
            failures++;
            $display("FAIL b2b_cat: got %h expected fb", cat_status);
        end
        idle(1);
        checks++;
        if (pops != 3 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL b2b_pops: pops=%0d errs=%0d expected 3 0", pops, err_cnt - e0);
        end
    endtask

    task automatic test_flags;
        int e0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'd65); send_byte(8'd65 + 8'(i)); send_byte(8'd65);
        end
        checks++;
        if (cat_status !== 8'h00) begin
            failures++;
            $display("FAIL flags_all_shot: got %h expected 00", cat_status);
        end
        send_byte(8'd65); send_byte(8'd96); send_byte(8'd65);
        checks++;
        if (cat_status !== 8'hFF) begin
            failures++;
            $display("FAIL flags_revive: got %h expected ff", cat_status);
        end
        e0 = err_cnt;
        send_byte(8'd65); send_byte(8'd80); send_byte(8'd65);
        idle(1);
        checks++;
        if (cat_status !== 8'hFF || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL flags_bad_arg: cat=%h errs=%0d expected ff 1", cat_status, err_cnt - e0);
        end
        e0 = err_cnt;
        send_byte(8'd65); send_byte(8'd72); send_byte(8'd66);
        idle(1);
        checks++;
        if (cat_status !== 8'hFF || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL flags_bad_end: cat=%h errs=%0d expected ff 1", cat_status, err_cnt - e0);
        end
        send_byte(8'd65); send_byte(8'd72); send_byte(8'd65);
        checks++;
        if (cat_status !== 8'h7F) begin
            failures++;
            $display("FAIL flags_bit7: got %h expected 7f", cat_status);
        end
    endtask

    task automatic test_key;
        int e0;
        int k0;
        e0 = err_cnt; k0 = kv_cnt;
        send_key(8'h00, 8'd66);
        checks++;
        if (key_out !== 128'h000102030405060708090a0b0c0d0e0f || key_valid !== 1'b1) begin
            failures++;
            $display("FAIL key_store: key=%h kv=%b expected 000102030405060708090a0b0c0d0e0f 1", key_out, key_valid);
        end
        idle(1);
        checks++;
        if (kv_cnt - k0 != 1 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL key_pulses: kv=%0d errs=%0d expected 1 0", kv_cnt - k0, err_cnt - e0);
        end
        e0 = err_cnt; k0 = kv_cnt;
        send_key(8'hF0, 8'd67);
        idle(1);
        checks++;
        if (key_out !== 128'h000102030405060708090a0b0c0d0e0f || err_cnt - e0 != 1 || kv_cnt - k0 != 0) begin
            failures++;
            $display("FAIL key_bad_end: key=%h errs=%0d kv=%0d expected old key 1 0", key_out, err_cnt - e0, kv_cnt - k0);
        end
        send_byte(8'd66);
        for (int i = 0; i < 16; i++) send_byte(8'd65);
        send_byte(8'd66);
        checks++;
        if (key_out !== {16{8'h41}}) begin
            failures++;
            $display("FAIL key_cmd_as_data: key=%h expected all 41", key_out);
        end
    endtask

    task automatic test_timeout;
        int e0;
        int first;
        logic busy15;
        e0 = err_cnt;
        first = 0;
        busy15 = 1'b0;
        send_byte(8'd65);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (cmd_err === 1'b1 && first == 0) first = k;
            if (k == 15) busy15 = busy;
        end
        checks++;
        if (first != 16 || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL timeout_fire: first=%0d errs=%0d expected 16 1", first, err_cnt - e0);
        end
        checks++;
        if (busy15 !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_busy: busy@15=%b busy@20=%b expected 1 0", busy15, busy);
        end
        e0 = err_cnt;
        send_byte(8'd65);
        idle(14);
        send_byte(8'd70);
        send_byte(8'd65);
        idle(1);
        checks++;
        if (cat_status !== 8'h5F || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL timeout_near_miss: cat=%h errs=%0d expected 5f 0", cat_status, err_cnt - e0);
        end
    endtask

    task automatic test_reset_midframe;
        int e0;
        int k0;
        e0 = err_cnt; k0 = kv_cnt;
        send_byte(8'd66);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        reset = 1'b1; rx_empty = 1'b0; rx_byte = 8'd66;
        @(posedge clk);
        #1;
        reset = 1'b0; rx_empty = 1'b1;
        idle(1);
        checks++;
        if (busy !== 1'b0 || key_out !== 128'h0 || cat_status !== 8'hFF || err_cnt - e0 != 0 || kv_cnt - k0 != 0) begin
            failures++;
            $display("FAIL reset_midframe: busy=%b key=%h cat=%h errs=%0d kv=%0d expected 0 0 ff 0 0",
                     busy, key_out, cat_status, err_cnt - e0, kv_cnt - k0);
        end
        send_key(8'h10, 8'd66);
        checks++;
        if (key_out !== 128'h101112131415161718191a1b1c1d1e1f) begin
            failures++;
            $display("FAIL reset_then_key: key=%h expected 101112131415161718191a1b1c1d1e1f", key_out);
        end
    endtask

    task automatic test_invalid_idle;
        int e0;
        logic busy_seen;
        e0 = err_cnt;
        busy_seen = 1'b0;
        send_byte(8'd90);
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0) busy_seen = 1'b1;
            idle(1);
        end
        checks++;
        if (err_cnt - e0 != 1 || busy_seen !== 1'b0) begin
            failures++;
            $display("FAIL invalid_idle: errs=%0d busy_seen=%b expected 1 0", err_cnt - e0, busy_seen);
        end
        checks++;
        if (rd_viol != 0) begin
            failures++;
            $display("FAIL rd_when_empty: count=%0d expected 0", rd_viol);
        end
        checks++;
        if (both_viol != 0) begin
            failures++;
            $display("FAIL kv_err_overlap: count=%0d expected 0", both_viol);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_empty = 1'b1;
        rx_byte  = 8'h00;
        #1;
        test_reset;
        test_back_to_back;
        test_flags;
        test_key;
        test_timeout;
        test_reset_midframe;
        test_invalid_idle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
